// File: rtl/onehot_decoder_seq.sv
// Sequenced 2-to-4 one-hot decoder: handshaked direct decode held for HOLD_CYCLES,
// or a self-running scan that walks the four one-hot positions, each held for DWELL cycles.
module onehot_decoder_seq #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned DWELL       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_en,
   input  logic       in_valid,
   input  logic [1:0] in_code,
   output logic       in_ready,
   output logic [3:0] out,
   output logic       out_valid,
   output logic       busy,
   output logic [7:0] scan_wraps
);

   localparam int unsigned MAX_CYC = (HOLD_CYCLES > DWELL) ? HOLD_CYCLES : DWELL;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned OUT_W   = 4;
   localparam int unsigned WRAP_W  = 8;

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_SCAN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [OUT_W-1:0]    r_out;
   logic [OUT_W-1:0]    w_out_nxt;
   logic                r_out_valid;
   logic                w_out_valid_nxt;
   logic                r_busy;
   logic [WRAP_W-1:0]   r_wraps;
   logic [WRAP_W-1:0]   w_wraps_nxt;
   logic                w_accept;

   function automatic logic [OUT_W-1:0] f_onehot(input logic [IDX_W-1:0] code);
      logic [OUT_W-1:0] v;
      case (code)
         2'd0:    v = 4'b0001;
         2'd1:    v = 4'b0010;
         2'd2:    v = 4'b0100;
         default: v = 4'b1000;
      endcase
      return v;
   endfunction

   assign in_ready   = (r_state == S_IDLE) && !scan_en;
   assign w_accept   = in_valid && in_ready;
   assign out        = r_out;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign scan_wraps = r_wraps;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic; outputs are registered from these values
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_idx_nxt       = r_idx;
      w_out_nxt       = r_out;
      w_out_valid_nxt = r_out_valid;
      w_wraps_nxt     = r_wraps;

      case (r_state)
         S_IDLE: begin
            w_out_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            if (scan_en) begin
               w_state_nxt     = S_SCAN;
               w_out_nxt       = f_onehot(2'd0);
               w_out_valid_nxt = 1'b1;
            end else if (w_accept) begin
               w_state_nxt     = S_HOLD;
               w_out_nxt       = f_onehot(in_code);
               w_out_valid_nxt = 1'b1;
            end
         end

         S_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt     = S_IDLE;
               w_out_nxt       = '0;
               w_out_valid_nxt = 1'b0;
               w_cnt_nxt       = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         S_SCAN: begin
            // Dropping scan_en abandons the current dwell immediately
            if (!scan_en) begin
               w_state_nxt     = S_IDLE;
               w_out_nxt       = '0;
               w_out_valid_nxt = 1'b0;
               w_cnt_nxt       = '0;
               w_idx_nxt       = '0;
            end else if (r_cnt == DWELL_LAST) begin
               w_cnt_nxt = '0;
               w_idx_nxt = r_idx + IDX_W'(1);
               w_out_nxt = f_onehot(r_idx + IDX_W'(1));
               if (r_idx == IDX_W'(3)) begin
                  w_wraps_nxt = r_wraps + WRAP_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt     = S_IDLE;
            w_out_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_wraps     <= '0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_out       <= w_out_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_wraps     <= w_wraps_nxt;
      end
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq with HOLD_CYCLES=4 and DWELL=2.
module tb_onehot_decoder_seq;

   logic       clk;
   logic       rst_n;
   logic       scan_en;
   logic       in_valid;
   logic [1:0] in_code;
   logic       in_ready;
   logic [3:0] out;
   logic       out_valid;
   logic       busy;
   logic [7:0] scan_wraps;

   int n_checks = 0;
   int n_fail   = 0;

   onehot_decoder_seq #(.HOLD_CYCLES(4), .DWELL(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .in_valid   (in_valid),
      .in_code    (in_code),
      .in_ready   (in_ready),
      .out        (out),
      .out_valid  (out_valid),
      .busy       (busy),
      .scan_wraps (scan_wraps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; scan_en = 1'b0; in_valid = 1'b0; in_code = 2'd0;
      #12;
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL reset_out: got %b want 0000", out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (scan_wraps !== 8'd0) begin n_fail++; $display("FAIL reset_wraps: got %0d want 0", scan_wraps); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      step();
      // Load a code, then reset mid-cycle while it is held
      in_valid = 1'b1; in_code = 2'd3;
      step();
      in_valid = 1'b0;
      n_checks++; if (out !== 4'b1000) begin n_fail++; $display("FAIL pre_async_out: got %b want 1000", out); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL async_reset_out: got %b want 0000", out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_in_ready: got %b want 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_direct();
      logic [3:0] exp_tab [4];
      exp_tab[0] = 4'b0001; exp_tab[1] = 4'b0010; exp_tab[2] = 4'b0100; exp_tab[3] = 4'b1000;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; in_code = 2'(c);
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL direct_ready_idle code %0d: got %b want 1", c, in_ready); end
         step();
         in_valid = 1'b0; in_code = 2'(3 - c);
         for (int k = 0; k < 4; k++) begin
            n_checks++; if (out !== exp_tab[c]) begin n_fail++; $display("FAIL direct_out code %0d cyc %0d: got %b want %b", c, k, out, exp_tab[c]); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL direct_valid code %0d cyc %0d: got %b want 1", c, k, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL direct_ready_hold code %0d cyc %0d: got %b want 0", c, k, in_ready); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL direct_busy code %0d cyc %0d: got %b want 1", c, k, busy); end
            step();
         end
         n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL direct_release code %0d: got %b want 0000", c, out); end
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL direct_release_valid code %0d: got %b want 0", c, out_valid); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL direct_release_busy code %0d: got %b want 0", c, busy); end
      end
   endtask

   task automatic test_ignore_busy();
      in_valid = 1'b1; in_code = 2'd2;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (out !== 4'b0100) begin n_fail++; $display("FAIL ignore_out cyc %0d: got %b want 0100", k, out); end
         in_valid = (k == 1); in_code = 2'd1;
         step();
      end
      in_valid = 1'b0;
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL ignore_release: got %b want 0000", out); end
      step();
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL ignore_no_second: got %b want 0000", out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_second_busy: got %b want 0", busy); end
      in_valid = 1'b1; in_code = 2'd1;
      step();
      in_valid = 1'b0;
      n_checks++; if (out !== 4'b0010) begin n_fail++; $display("FAIL ignore_next_accept: got %b want 0010", out); end
      for (int k = 0; k < 4; k++) step();
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL ignore_next_release: got %b want 0000", out); end
   endtask

   task automatic test_scan();
      logic [3:0] exp_out;
      n_checks++; if (scan_wraps !== 8'd0) begin n_fail++; $display("FAIL scan_wraps_start: got %0d want 0", scan_wraps); end
      scan_en = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         exp_out = 4'b0001 << ((i / 2) % 4);
         n_checks++; if (out !== exp_out) begin n_fail++; $display("FAIL scan_out cyc %0d: got %b want %b", i, out, exp_out); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL scan_valid cyc %0d: got %b want 1", i, out_valid); end
         n_checks++; if (scan_wraps !== 8'(i / 8)) begin n_fail++; $display("FAIL scan_wraps cyc %0d: got %0d want %0d", i, scan_wraps, i / 8); end
         step();
      end
      scan_en = 1'b0;
      step();
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL scan_exit_out: got %b want 0000", out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL scan_exit_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL scan_exit_busy: got %b want 0", busy); end
      n_checks++; if (scan_wraps !== 8'd2) begin n_fail++; $display("FAIL scan_exit_wraps: got %0d want 2", scan_wraps); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL scan_exit_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_priority();
      scan_en = 1'b1; in_valid = 1'b1; in_code = 2'd3;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready: got %b want 0", in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++; if (out !== 4'b0001) begin n_fail++; $display("FAIL prio_scan_entry: got %b want 0001", out); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy: got %b want 1", busy); end
      step();
      n_checks++; if (out !== 4'b0001) begin n_fail++; $display("FAIL prio_dwell: got %b want 0001", out); end
      scan_en = 1'b0;
      step();
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL prio_exit: got %b want 0000", out); end
      step();
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL prio_no_decode: got %b want 0000", out); end
      n_checks++; if (scan_wraps !== 8'd2) begin n_fail++; $display("FAIL prio_wraps: got %0d want 2", scan_wraps); end
   endtask

   task automatic test_reset_mid_scan();
      scan_en = 1'b1;
      step();
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (out !== 4'b0100) begin n_fail++; $display("FAIL midscan_pre: got %b want 0100", out); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL midscan_rst_out: got %b want 0000", out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_valid: got %b want 0", out_valid); end
      n_checks++; if (scan_wraps !== 8'd0) begin n_fail++; $display("FAIL midscan_rst_wraps: got %0d want 0", scan_wraps); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_busy: got %b want 0", busy); end
      step();
      @(negedge clk); rst_n = 1'b1;
      step();
      n_checks++; if (out !== 4'b0001) begin n_fail++; $display("FAIL midscan_restart: got %b want 0001", out); end
      step(); step();
      n_checks++; if (out !== 4'b0010) begin n_fail++; $display("FAIL midscan_advance: got %b want 0010", out); end
      scan_en = 1'b0;
      step();
      n_checks++; if (out !== 4'b0000) begin n_fail++; $display("FAIL midscan_exit: got %b want 0000", out); end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_ignore_busy();
      test_scan();
      test_priority();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Sequenced 2-to-4 one-hot decoder that turns a 2-bit code back into a one-hot line.
- Direct mode: a 2-bit code is accepted over a valid/ready handshake. The matching one-hot output is driven for a fixed number of cycles.
- Scan mode: the block cycles through all four one-hot outputs on its own, for example to drive digit or LED enables.
- It sits downstream of the 4-to-2 encoder exercises as their decoding counterpart.

Parameters:
HOLD_CYCLES, 4, cycles a direct-mode decoded output is held (>=1)
DWELL, 8, cycles each one-hot position is held in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
scan_en  input  1  level; 1 requests scan mode
in_valid  input  1  direct-mode code valid
in_code  input  2  code to decode
in_ready  output  1  block can accept a code
out  output  4  registered one-hot decoded output
out_valid  output  1  out holds a valid one-hot value
busy  output  1  state != IDLE
scan_wraps  output  8  completed full scans (3->0 transitions), mod 256

Behaviour:
- One clock domain; reset is asynchronous and active-low. rst_n=0 immediately forces all state and registered outputs to reset values.
- Reset values: state=IDLE, out=4'b0000, out_valid=0, busy=0, scan_wraps=0, internal scan index=0, cycle counter=0. in_ready follows its equation (1 if scan_en=0).
- States: IDLE, HOLD, SCAN.
- in_ready = (state==IDLE) && !scan_en. This is combinational; no other path sets it.
- accept = in_valid && in_ready.
- IDLE:
  - out=0, out_valid=0.
  - If scan_en=1, go to SCAN next cycle. Scan has priority over a simultaneous in_valid, which is not accepted.
  - Else on accept, go to HOLD next cycle.
- HOLD entry (latency 1 cycle after the accept edge):
  - out=1<<in_code as captured at acceptance; out_valid=1.
  - Mapping: 00->0001, 01->0010, 10->0100, 11->1000.
- HOLD:
  - out/out_valid stay stable for exactly HOLD_CYCLES cycles, then return to IDLE with out=0, out_valid=0.
  - in_code/in_valid changes are ignored. scan_en is ignored until back in IDLE.
  - Minimum spacing between back-to-back accepts is HOLD_CYCLES+1 cycles.
- SCAN entry: scan index=0, out=0001, out_valid=1.
- SCAN:
  - Each position is held exactly DWELL cycles, then the index increments 0->1->2->3->0.
  - On each 3->0 step, scan_wraps increments, wrapping 255->0.
- SCAN exit:
  - scan_en sampled 0 at any edge moves to IDLE on that edge: out=0, out_valid=0, index cleared to 0. The current dwell is abandoned.
  - scan_wraps is not cleared by exit; only reset clears it.
- Invariant: out_valid=1 implies out is exactly one-hot; out_valid=0 implies out=0.
- Counter width is sufficient for max(HOLD_CYCLES, DWELL); no overflow for legal parameters.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> out=0000, out_valid=0, busy=0, scan_wraps=0 immediately, without waiting for a clock edge; in_ready=1 with scan_en=0.
2. Direct decode, HOLD_CYCLES=4: accept codes 00,01,10,11 in turn -> out=0001/0010/0100/1000 one cycle after accept, each held 4 cycles, then 0000; in_ready=0 throughout HOLD.
3. Ignore while busy: accept 10, then pulse in_valid with code 01 during HOLD -> out stays 0100 for 4 cycles; no second decode; next accept only after return to IDLE.
4. Scan, DWELL=2: hold scan_en=1 for 20 cycles -> out sequence 0001,0001,0010,0010,0100,0100,1000,1000,repeat; scan_wraps=2 after 16 scan cycles; drop scan_en -> out=0000 next edge, scan_wraps retained.
5. Priority: in IDLE assert scan_en=1 and in_valid=1 (code 11) in the same cycle -> in_ready=0, SCAN entered with out=0001, code 11 never decoded.
6. Reset mid-scan: rst_n=0 while out=0100 -> out=0000, out_valid=0, scan_wraps=0 asynchronously; after release with scan_en=1, scan restarts at 0001.
